// File: rtl/vdp_pkg.sv
// Shared video-pipeline types: palette write entry, fill sequencer and byte-phase states.
// Pure declarations, no logic.
package vdp_pkg;

  localparam int PAL_ADDR_W = 9;
  localparam int PAL_DATA_W = 24;

  typedef struct packed {
    logic [PAL_ADDR_W-1:0] addr;
    logic [PAL_DATA_W-1:0] rgb;
  } pal_wr_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_WAIT,
    FILL_RUN
  } fill_state_t;

  typedef enum logic [1:0] {
    PH_R,
    PH_G,
    PH_B
  } byte_phase_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with fall-through read data (head visible while !empty).
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps the count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/palette_write_ctrl.sv
// Palette RAM write side: assembles host R,G,B bytes into entries and commits them only in blanking.
// B byte to pal_we is 2 cycles minimum; wr_ready drops only while the commit FIFO is full.
module palette_write_ctrl
  import vdp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = 512
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix,
  input  logic                  de,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_index,
  input  logic [PAL_ADDR_W-1:0] wr_data,
  input  logic                  clr_start,
  input  logic [PAL_DATA_W-1:0] clr_colour,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  pal_we,
  output logic [PAL_ADDR_W-1:0] pal_addr,
  output logic [PAL_DATA_W-1:0] pal_wdata,
  output logic                  pending
);

  localparam logic [PAL_ADDR_W-1:0] FILL_LAST = PAL_ADDR_W'(ENTRIES - 1);

  logic [PAL_ADDR_W-1:0] cur_index;
  byte_phase_t           phase;
  logic [7:0]            red;
  logic [7:0]            grn;

  fill_state_t           fill_state;
  logic [PAL_DATA_W-1:0] fill_colour;
  logic [PAL_ADDR_W-1:0] fill_cnt;

  pal_wr_t push_entry;
  pal_wr_t head_entry;
  logic    fifo_full;
  logic    fifo_empty;
  logic    host_hs;
  logic    push;
  logic    pop;

  assign wr_ready   = !fifo_full;
  assign host_hs    = wr_valid && wr_ready;
  assign push       = host_hs && !wr_index && (phase == PH_B);
  assign push_entry = '{addr: cur_index, rgb: {red, grn, wr_data[7:0]}};

  // Queued writes never interleave with a running fill; de gates commits combinationally.
  assign pop = !de && !fifo_empty && (fill_state != FILL_RUN);

  assign pending = !fifo_empty || (fill_state != FILL_IDLE) || (phase != PH_R);

  sync_fifo #(
    .WIDTH ($bits(pal_wr_t)),
    .DEPTH (DEPTH)
  ) u_commit_fifo (
    .clk      (clk_pix),
    .rst      (rst_pix),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Byte assembly; a new index discards any partially received colour.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cur_index <= '0;
      phase     <= PH_R;
      red       <= '0;
      grn       <= '0;
    end else if (host_hs) begin
      if (wr_index) begin
        cur_index <= wr_data;
        phase     <= PH_R;
      end else begin
        case (phase)
          PH_R: begin
            red   <= wr_data[7:0];
            phase <= PH_G;
          end
          PH_G: begin
            grn   <= wr_data[7:0];
            phase <= PH_B;
          end
          PH_B: begin
            cur_index <= cur_index + PAL_ADDR_W'(1);
            phase     <= PH_R;
          end
          default: phase <= PH_R;
        endcase
      end
    end
  end

  // Fill sequencer and the registered palette write port share one block so the
  // two write sources are arbitrated in one place.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      fill_state  <= FILL_IDLE;
      fill_colour <= '0;
      fill_cnt    <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      pal_we      <= 1'b0;
      pal_addr    <= '0;
      pal_wdata   <= '0;
    end else begin
      clr_done <= 1'b0;
      pal_we   <= 1'b0;

      if (pop) begin
        pal_we    <= 1'b1;
        pal_addr  <= head_entry.addr;
        pal_wdata <= head_entry.rgb;
      end

      case (fill_state)
        FILL_IDLE: begin
          if (clr_start) begin
            fill_colour <= clr_colour;
            clr_busy    <= 1'b1;
            fill_state  <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          // Let everything queued ahead of the fill request commit first.
          if (fifo_empty) begin
            fill_cnt   <= '0;
            fill_state <= FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (!de) begin
            pal_we    <= 1'b1;
            pal_addr  <= fill_cnt;
            pal_wdata <= fill_colour;
            fill_cnt  <= fill_cnt + PAL_ADDR_W'(1);
            if (fill_cnt == FILL_LAST) begin
              clr_done   <= 1'b1;
              clr_busy   <= 1'b0;
              fill_state <= FILL_IDLE;
            end
          end
        end
        default: fill_state <= FILL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_write_ctrl.sv
// Scoreboard bench for palette_write_ctrl: stimulus pushes expected palette writes, a monitor pops on pal_we.
// Model tracks index/phase from the host byte protocol and expands fills into 512 entries.
module tb_palette_write_ctrl;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic        de;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_index;
  logic [8:0]  wr_data;
  logic        clr_start;
  logic [23:0] clr_colour;
  logic        clr_busy;
  logic        clr_done;
  logic        pal_we;
  logic [8:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic        pending;

  always #5 clk_pix = ~clk_pix;

  palette_write_ctrl #(.DEPTH(4), .ENTRIES(512)) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .de         (de),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .clr_start  (clr_start),
    .clr_colour (clr_colour),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_wdata  (pal_wdata),
    .pending    (pending)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [23:0] rgb;
  } exp_t;

  exp_t sq[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;

  // Reference model state (host protocol level)
  int         m_idx = 0;
  int         m_ph  = 0;
  logic [7:0] m_r, m_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic is_idx, input logic [8:0] d);
    exp_t e;
    if (is_idx) begin
      m_idx = int'(d);
      m_ph  = 0;
    end else if (m_ph == 0) begin
      m_r  = d[7:0];
      m_ph = 1;
    end else if (m_ph == 1) begin
      m_g  = d[7:0];
      m_ph = 2;
    end else begin
      e.addr = 9'(m_idx);
      e.rgb  = {m_r, m_g, d[7:0]};
      sq.push_back(e);
      m_idx = (m_idx + 1) % 512;
      m_ph  = 0;
    end
  endtask

  // Drive one byte until accepted; if stuck long while de is high, open blanking.
  task automatic send_byte(input logic is_idx, input logic [8:0] d);
    int   waited;
    logic acc;
    waited   = 0;
    wr_valid = 1'b1;
    wr_index = is_idx;
    wr_data  = d;
    forever begin
      acc = wr_ready;
      @(posedge clk_pix);
      #1;
      if (acc) break;
      waited++;
      if (waited > 20) de = 1'b0;
      if (waited > 2000) begin
        chk("send_timeout", 32'(waited), 0);
        wr_valid = 1'b0;
        return;
      end
    end
    wr_valid = 1'b0;
    model_byte(is_idx, d);
  endtask

  task automatic send_triplet(input logic [23:0] rgb);
    send_byte(1'b0, {1'b0, rgb[23:16]});
    send_byte(1'b0, {1'b0, rgb[15:8]});
    send_byte(1'b0, {1'b0, rgb[7:0]});
  endtask

  task automatic start_fill(input logic [23:0] c);
    exp_t e;
    clr_colour = c;
    clr_start  = 1'b1;
    @(posedge clk_pix);
    #1;
    clr_start  = 1'b0;
    clr_colour = 24'($urandom);
    for (int a = 0; a < 512; a++) begin
      e.addr = 9'(a);
      e.rgb  = c;
      sq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sq.size() > 0 && n < 8000) begin
      @(posedge clk_pix);
      #1;
      n++;
    end
    repeat (2) @(posedge clk_pix);
    #1;
    chk(name, 32'(sq.size()), 0);
  endtask

  // Monitor: de as seen by the edge that produced this cycle's pal_we
  logic de_at_edge;
  always @(posedge clk_pix) de_at_edge <= de;

  always @(negedge clk_pix) begin
    exp_t e;
    if (pal_we === 1'b1) begin
      chk("we_in_blank", 32'(de_at_edge), 0);
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                 pal_addr, pal_wdata, $time);
      end else begin
        e = sq.pop_front();
        chk("pal_addr", 32'(pal_addr), 32'(e.addr));
        chk("pal_wdata", 32'(pal_wdata), 32'(e.rgb));
      end
    end
    if (clr_done === 1'b1) begin
      done_cnt++;
      chk("done_we", 32'(pal_we), 1);
      chk("done_addr", 32'(pal_addr), 32'h1FF);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [23:0] c5;
    rst_pix    = 1'b1;
    de         = 1'b0;
    wr_valid   = 1'b0;
    wr_index   = 1'b0;
    wr_data    = '0;
    clr_start  = 1'b0;
    clr_colour = '0;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_we", 32'(pal_we), 0);
    chk("rst_addr", 32'(pal_addr), 0);
    chk("rst_wdata", 32'(pal_wdata), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    rst_pix = 1'b0;
    @(posedge clk_pix);
    #1;

    // Basic triplet and its latency
    send_byte(1'b1, 9'h010);
    send_byte(1'b0, 9'h011);
    send_byte(1'b0, 9'h022);
    send_byte(1'b0, 9'h033);
    chk("lat_n1_we", 32'(pal_we), 0);
    @(posedge clk_pix);
    #1;
    chk("lat_n2_we", 32'(pal_we), 1);
    chk("lat_n2_addr", 32'(pal_addr), 32'h010);
    chk("lat_n2_data", 32'(pal_wdata), 32'h112233);
    send_triplet(24'h445566);
    wait_drain("drain_basic");

    // Index wrap 511 -> 0
    send_byte(1'b1, 9'h1FF);
    send_triplet(24'($urandom));
    send_triplet(24'($urandom));
    wait_drain("drain_wrap");

    // Backpressure while active video
    de = 1'b1;
    for (int t = 0; t < 4; t++) send_triplet(24'($urandom));
    repeat (5) @(posedge clk_pix);
    #1;
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_pending", 32'(pending), 1);
    de = 1'b0;
    send_triplet(24'hA5C3E1);
    wait_drain("drain_full");

    // Partial triplet discarded by index load
    send_byte(1'b0, 9'h0AA);
    send_byte(1'b0, 9'h0BB);
    chk("partial_pending", 32'(pending), 1);
    send_byte(1'b1, 9'h040);
    chk("partial_cleared", 32'(pending), 0);
    send_triplet(24'h123456);
    wait_drain("drain_partial");

    // Fill after queued writes, with de toggling mid-fill
    de = 1'b1;
    send_byte(1'b1, 9'h0C0);
    send_triplet(24'($urandom));
    send_triplet(24'($urandom));
    start_fill(24'h0000FF);
    chk("fill_busy", 32'(clr_busy), 1);
    de = 1'b0;
    n = 0;
    while (clr_busy && n < 8000) begin
      @(posedge clk_pix);
      #1;
      de = ($urandom_range(0, 3) == 0);
      n++;
    end
    de = 1'b0;
    chk("fill_busy_end", 32'(clr_busy), 0);
    wait_drain("drain_fill");
    chk("done_count", 32'(done_cnt), 1);

    // Reset in the middle of a fill
    c5 = 24'($urandom);
    start_fill(c5);
    n = 0;
    while (!(pal_we && pal_addr == 9'd100) && n < 4000) begin
      @(posedge clk_pix);
      #1;
      n++;
    end
    chk("fill_reach_100", 32'(pal_addr), 100);
    rst_pix = 1'b1;
    @(posedge clk_pix);
    #1;
    sq.delete();
    m_idx = 0;
    m_ph  = 0;
    chk("midrst_we", 32'(pal_we), 0);
    chk("midrst_busy", 32'(clr_busy), 0);
    chk("midrst_pending", 32'(pending), 0);
    rst_pix = 1'b0;
    repeat (4) @(posedge clk_pix);
    #1;
    send_triplet(24'hFEDCBA);
    wait_drain("drain_after_rst");
    chk("done_count_rst", 32'(done_cnt), 1);

    // Randomized byte stream with random blanking
    for (int i = 0; i < 400; i++) begin
      de = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < 15) send_byte(1'b1, 9'($urandom));
      else send_byte(1'b0, 9'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk_pix);
      #1;
    end
    de = 1'b0;
    wait_drain("drain_random");
    chk("pending_end", 32'(pending), 32'(m_ph != 0));
    chk("busy_end", 32'(clr_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
